clock_div_detect: RTL
=====================

CLOCK_DIV_DETECT -- requirements
Module: clock_div_detect

Interface
REQ-001 Parameter LOCK_CNT, default 3: number of consecutive equal legal periods required before a ratio is reported (range 2..7).
REQ-002 Parameter TIMEOUT, default 32: clk_in cycles without a detected clk_meas rising edge before error (range 16..63).
REQ-003 clk_in  input  1  reference clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clk_meas  input  1  divided clock under measurement, derived from and synchronous to clk_in.
REQ-006 start  input  1  single-cycle pulse that begins a measurement.
REQ-007 div_det  output  4  detected ratio, one-hot: 4'b0010 = /2, 4'b0100 = /4, 4'b1000 = /8, 4'b0000 = none.
REQ-008 valid  output  1  div_det holds a locked result; level, held until next start or reset.
REQ-009 busy  output  1  measurement in progress.
REQ-010 err  output  1  measurement failed; level, held until next start or reset.

Function
REQ-011 The block SHALL register clk_meas once per cycle and define a rising edge as current sample 1 and previous sample 0.
REQ-012 The FSM SHALL have states IDLE, SYNC, MEASURE and DONE.
REQ-013 IDLE: start=1 -> SYNC; busy=1, valid=0, err=0, div_det=0 on the next cycle.
REQ-014 SYNC: first rising edge -> MEASURE; the period counter restarts at that edge.
REQ-015 MEASURE: period P = clk_in cycles between consecutive rising edges; counter is 6 bits and saturates.
REQ-016 The first legal P (2, 4 or 8) SHALL become the reference period and set match count to 1.
REQ-017 A following P equal to the reference SHALL increment match count; a legal but different P SHALL replace the reference and reset match count to 1.
REQ-018 Any P not in {2,4,8} SHALL set err=1, div_det=0 and go to DONE.
REQ-019 When match count reaches LOCK_CNT, the block SHALL set div_det to the one-hot code of the reference, valid=1, busy=0 and go to DONE, registered one cycle after the closing edge.
REQ-020 In SYNC or MEASURE, TIMEOUT cycles without an edge SHALL set err=1, div_det=0, busy=0 and go to DONE.
REQ-021 A constant clk_meas, including a /1 pass-through that sampling cannot resolve, SHALL therefore end in err; 4'b0001 is never reported.
REQ-022 start during SYNC or MEASURE SHALL be ignored.
REQ-023 start in DONE SHALL clear valid, err and div_det and enter SYNC.
REQ-024 valid and err SHALL never be 1 in the same cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, div_det=0, valid=0, busy=0, err=0 and clear all counters and the sample register, including mid-measurement.
REQ-026 After rst_n deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-027 With CLOCK_DIV_DETECT_DUTY_EN defined, the block SHALL also count high-time per period; a high-time other than P/2 SHALL set err=1 and go to DONE as in REQ-018.
REQ-028 Without CLOCK_DIV_DETECT_DUTY_EN, duty cycle SHALL NOT be checked and no high-time counter SHALL be built.

Verification
REQ-029 clk_meas toggling every clk_in cycle (/2), start pulse -> div_det=4'b0010, valid=1 one cycle after the 4th rising edge, err=0.
REQ-030 clk_meas /8, LOCK_CNT=3 -> valid=1 with div_det=4'b1000 one cycle after the edge closing the 3rd 8-cycle period; busy drops the same cycle.
REQ-031 clk_meas held 0 after start -> err=1, div_det=0 after 32 cycles; repeat with clk_meas=clk_in (/1) -> err=1.
REQ-032 /4 switching to /8 after two periods -> reference replaced, lock only after three /8 periods, div_det=4'b1000.
REQ-033 Period 3 injected (high 1, low 2) -> err=1 at that edge; rst_n pulsed low mid-MEASURE -> all outputs 0 asynchronously, start re-locks correctly.
REQ-034 With CLOCK_DIV_DETECT_DUTY_EN, a /4 clock with high-time 1 -> err=1; without the macro, the same stimulus -> div_det=4'b0100, valid=1.

Source files
------------

// File: rtl/clock_div_detect.sv
// rtl/clock_div_detect.sv - measures the ratio of a synchronous divided clock (/2, /4, /8)
// Optional duty-cycle check enabled by defining CLOCK_DIV_DETECT_DUTY_EN.
module clock_div_detect #(
  parameter int LOCK_CNT = 3,
  parameter int TIMEOUT  = 32
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clk_meas,
  input  logic       start,
  output logic [3:0] div_det,
  output logic       valid,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SYNC    = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [2:0] LOCK_W = 3'(LOCK_CNT);
  localparam logic [5:0] TO_W   = 6'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic       meas_q, meas_d;
  logic [5:0] per_q, per_d;
  logic [2:0] match_q, match_d;
  logic [3:0] ref_q, ref_d;
  logic [3:0] div_q, div_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic       rise;
  logic [5:0] per_inc;
  logic [3:0] p_code;
  logic       duty_ok;

  assign rise    = clk_meas & ~meas_q;
  assign per_inc = (per_q == 6'h3f) ? per_q : per_q + 6'd1;

  // per_q holds the cycle distance since the last edge, so at an edge it is the period
  always_comb begin
    case (per_q)
      6'd2:    p_code = 4'b0010;
      6'd4:    p_code = 4'b0100;
      6'd8:    p_code = 4'b1000;
      default: p_code = 4'b0000;
    endcase
  end

`ifdef CLOCK_DIV_DETECT_DUTY_EN
  logic [5:0] hi_q, hi_d;

  always_comb begin
    hi_d = hi_q;
    if (rise) begin
      hi_d = 6'd1;
    end else if (clk_meas && hi_q != 6'h3f) begin
      hi_d = hi_q + 6'd1;
    end
  end

  assign duty_ok = (hi_q == {1'b0, per_q[5:1]});

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 6'd0;
    end else begin
      hi_q <= hi_d;
    end
  end
`else
  assign duty_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    meas_d  = clk_meas;
    per_d   = per_inc;
    match_d = match_q;
    ref_d   = ref_q;
    div_d   = div_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SYNC;
          per_d   = 6'd1;
          match_d = 3'd0;
          ref_d   = 4'd0;
          div_d   = 4'd0;
          valid_d = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SYNC: begin
        if (rise) begin
          state_d = S_MEASURE;
          per_d   = 6'd1;
        end else if (per_q >= TO_W) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          div_d   = 4'd0;
          busy_d  = 1'b0;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          per_d = 6'd1;
          if (p_code == 4'd0 || !duty_ok) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            div_d   = 4'd0;
            busy_d  = 1'b0;
          end else if (match_q != 3'd0 && p_code == ref_q) begin
            match_d = match_q + 3'd1;
            if (match_q + 3'd1 == LOCK_W) begin
              state_d = S_DONE;
              div_d   = p_code;
              valid_d = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            ref_d   = p_code;
            match_d = 3'd1;
          end
        end else if (per_q >= TO_W) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          div_d   = 4'd0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      meas_q  <= 1'b0;
      per_q   <= 6'd0;
      match_q <= 3'd0;
      ref_q   <= 4'd0;
      div_q   <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      meas_q  <= meas_d;
      per_q   <= per_d;
      match_q <= match_d;
      ref_q   <= ref_d;
      div_q   <= div_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign div_det = div_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
